// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the architectural PC, fetches one word at a time
// over a req/gnt/rvalid memory port and hands it to decode over valid/ready.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic [31:0] npc,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        fetch_err,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  // Bounds are held in 33 bits so IM_BASE + 4*IM_WORDS cannot wrap.
  localparam logic [32:0] IM_LO = {1'b0, IM_BASE};
  localparam logic [32:0] IM_HI = IM_LO + (33'(IM_WORDS) * 33'd4);

  function automatic logic npc_legal(input logic [31:0] addr);
    logic [32:0] addr33;
    addr33 = {1'b0, addr};
    return (addr[1:0] == 2'b00) && (addr33 >= IM_LO) && (addr33 < IM_HI);
  endfunction

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] count_q, count_d;
  logic        err_q, err_d;
  logic        imem_req_s;
  logic        instr_valid_s;
  logic        npc_ok_s;

  assign npc_ok_s = npc_legal(npc);

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0000_0000;
      count_q <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; responses outside WAIT are dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_gnt) state_d = S_WAIT;
        else          state_d = S_REQ;
      end
      S_WAIT: begin
        if (imem_rvalid) state_d = S_VALID;
        else             state_d = S_WAIT;
      end
      S_VALID: begin
        if (instr_ready) state_d = npc_ok_s ? S_REQ : S_ERR;
        else             state_d = S_VALID;
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: capture response, advance PC and count on acceptance.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    err_d   = err_q;
    case (state_q)
      S_WAIT: begin
        if (imem_rvalid) instr_d = imem_rdata;
        else             instr_d = instr_q;
      end
      S_VALID: begin
        if (instr_ready) begin
          pc_d    = npc;
          count_d = count_q + 32'd1;
          err_d   = err_q | ~npc_ok_s;
        end else begin
          pc_d    = pc_q;
          count_d = count_q;
        end
      end
      default: begin
        pc_d = pc_q;
      end
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    imem_req_s    = 1'b0;
    instr_valid_s = 1'b0;
    case (state_q)
      S_REQ:   imem_req_s    = 1'b1;
      S_VALID: instr_valid_s = 1'b1;
      default: begin
        imem_req_s    = 1'b0;
        instr_valid_s = 1'b0;
      end
    endcase
  end

  assign imem_req    = imem_req_s;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_s;
  assign pc          = pc_q;
  assign pc4         = pc_q + 32'd4;
  assign fetch_err   = err_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: expected requests and fetched words are queued
// when stimulus is driven and compared when the DUT presents them.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] npc = 32'h0;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        fetch_err;
  logic [31:0] instr_count;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] model_pc;
  logic [31:0] cnt_exp;
  int          n_checks = 0;
  int          n_fail = 0;

  ifu_fetch dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .npc(npc), .pc(pc), .pc4(pc4), .fetch_err(fetch_err), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= 32'h0000_3000) && (a < 32'h0000_4000);
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_ready = 1'b0;
    repeat (3) step();
    check_eq("rst_pc", pc, 32'h0000_3000);
    check_eq("rst_req", {31'b0, imem_req}, 32'd0);
    check_eq("rst_valid", {31'b0, instr_valid}, 32'd0);
    check_eq("rst_count", instr_count, 32'd0);
    check_eq("rst_err", {31'b0, fetch_err}, 32'd0);
    check_eq("rst_instr", instr, 32'd0);
    sb_q.delete();
    addr_q.delete();
    addr_q.push_back(32'h0000_3000);
    model_pc = 32'h0000_3000;
    cnt_exp = 32'd0;
    reset = 1'b1;
    #1;
    check_eq("rel_no_req", {31'b0, imem_req}, 32'd0);
  endtask

  task automatic wait_req(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) check_eq("req_timeout", {31'b0, imem_req}, 32'd1);
  endtask

  task automatic fetch(input int gnt_dly, input logic [31:0] rdata,
                       input int rdy_dly, input logic [31:0] npc_v);
    logic        ok;
    logic [31:0] exp_addr;
    exp_t        e;
    wait_req(ok);
    if (ok) begin
      exp_addr = (addr_q.size() > 0) ? addr_q.pop_front() : 32'hFFFF_FFFF;
      check_eq("req_addr", imem_addr, exp_addr);
      for (int i = 0; i < gnt_dly; i++) begin
        step();
        check_eq("req_hold", {31'b0, imem_req}, 32'd1);
        check_eq("addr_hold", imem_addr, exp_addr);
      end
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      check_eq("wait_no_req", {31'b0, imem_req}, 32'd0);
      imem_rvalid = 1'b1;
      imem_rdata = rdata;
      sb_q.push_back('{instr: rdata, pc: model_pc});
      step();
      imem_rvalid = 1'b0;
      check_eq("valid", {31'b0, instr_valid}, 32'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_eq("instr", instr, e.instr);
        check_eq("pc", pc, e.pc);
        check_eq("pc4", pc4, e.pc + 32'd4);
        for (int i = 0; i < rdy_dly; i++) begin
          step();
          check_eq("instr_hold", instr, e.instr);
          check_eq("pc_hold", pc, e.pc);
          check_eq("no_2nd_req", {31'b0, imem_req}, 32'd0);
        end
      end
      instr_ready = 1'b1;
      npc = npc_v;
      step();
      instr_ready = 1'b0;
      cnt_exp = cnt_exp + 32'd1;
      model_pc = npc_v;
      check_eq("count", instr_count, cnt_exp);
      check_eq("pc_upd", pc, npc_v);
      if (legal(npc_v)) begin
        addr_q.push_back(npc_v);
        check_eq("next_req", {31'b0, imem_req}, 32'd1);
        check_eq("no_err", {31'b0, fetch_err}, 32'd0);
      end
    end
  endtask

  task automatic err_check(input logic [31:0] bad_pc);
    for (int i = 0; i < 4; i++) begin
      imem_rvalid = (i == 1);
      imem_rdata = 32'hDEAD_BEEF;
      check_eq("err_flag", {31'b0, fetch_err}, 32'd1);
      check_eq("err_req", {31'b0, imem_req}, 32'd0);
      check_eq("err_valid", {31'b0, instr_valid}, 32'd0);
      check_eq("err_pc", pc, bad_pc);
      check_eq("err_count", instr_count, cnt_exp);
      step();
    end
    imem_rvalid = 1'b0;
  endtask

  initial begin
    #1;
    // Run A: normal fetches ending in a misaligned npc.
    do_reset();
    step();
    check_eq("first_req", {31'b0, imem_req}, 32'd1);
    check_eq("first_addr", imem_addr, 32'h0000_3000);
    fetch(0, 32'h3C01_0001, 0, 32'h0000_3004);
    fetch(3, 32'h1111_1111, 5, 32'h0000_3010);
    fetch(0, 32'h2222_2222, 0, 32'h0000_3FFC);
    fetch(1, 32'h3333_3333, 2, 32'h0000_3006);
    err_check(32'h0000_3006);

    // Run B: reset mid-WAIT, stale response, then out-of-range npc.
    do_reset();
    step();
    check_eq("b_req", {31'b0, imem_req}, 32'd1);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    reset = 1'b0;
    step();
    check_eq("b_rst_req", {31'b0, imem_req}, 32'd0);
    check_eq("b_rst_pc", pc, 32'h0000_3000);
    reset = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    check_eq("stale_req", {31'b0, imem_req}, 32'd1);
    step();
    imem_rvalid = 1'b0;
    check_eq("stale_instr", instr, 32'd0);
    check_eq("stale_valid", {31'b0, instr_valid}, 32'd0);
    check_eq("stale_addr", imem_addr, 32'h0000_3000);
    fetch(0, 32'h4444_4444, 1, 32'h0000_4000);
    err_check(32'h0000_4000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
